// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter sharing one external JK flop; tracks expected flop state and flags mismatches.
// Latency: gnt 1 cycle after req, rsp 2 cycles after gnt; one op per 3 cycles, req ignored while busy.
module jk_cmd_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  output logic [NREQ-1:0]   gnt,
  output logic              j,
  output logic              k,
  input  logic              q,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_q,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] pick;
  logic           found;
  logic [1:0]     win_cmd;
  logic [1:0]     op;
  logic           shadow;
  logic           shadow_valid;
  logic           pred;
  logic           chk;

  // Search starts just after the previous winner and wraps.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[IDW'((int'(last) + i) % NREQ)]) begin
        found = 1'b1;
        pick  = IDW'((int'(last) + i) % NREQ);
      end
    end
  end

  assign win_cmd = cmd[{pick, 1'b0} +: 2];

  // Set/reset define the flop outright; hold/toggle only predict relative to the last sample.
  always_comb begin
    case (op)
      2'b01:   pred = 1'b0;
      2'b10:   pred = 1'b1;
      2'b11:   pred = ~shadow;
      default: pred = shadow;
    endcase
    chk = shadow_valid | (op[1] ^ op[0]);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gnt          <= '0;
      j            <= 1'b0;
      k            <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_q        <= 1'b0;
      err          <= 1'b0;
      last         <= IDW'(NREQ - 1);
      win_id       <= '0;
      op           <= 2'b00;
      shadow       <= 1'b0;
      shadow_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            j      <= win_cmd[1];
            k      <= win_cmd[0];
            op     <= win_cmd;
            win_id <= pick;
            last   <= pick;
            state  <= DRIVE;
          end else begin
            gnt <= '0;
          end
        end
        DRIVE: begin
          gnt   <= '0;
          j     <= 1'b0;
          k     <= 1'b0;
          state <= SAMPLE;
        end
        SAMPLE: begin
          rsp_q     <= q;
          rsp_id    <= win_id;
          rsp_valid <= 1'b1;
          if (chk && (q != pred))
            err <= 1'b1;
          if (op[1] ^ op[0])
            shadow_valid <= 1'b1;
          shadow <= q;
          state  <= IDLE;
        end
        default: begin
          gnt   <= '0;
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/jk_cmd_arbiter.md
Name: jk_cmd_arbiter

Overview:
- Shares one external JK flip-flop (jkf) among NREQ requesters.
- Each requester posts a 2-bit command: hold, reset, set or toggle.
- Round-robin arbitration picks one winner. The block drives j/k for exactly one clock edge, samples q afterwards, and returns the result tagged with the winner's ID.
- A shadow model of the flop's expected state raises a sticky error on any mismatch. The block sits between the stimulus/agent layer and the jkf instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of requester ID (derived; do not override).

Ports:
- clock  in  1  system clock, all flops posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held until matching gnt bit seen.
- cmd  in  2*NREQ  requester i command at [2i+1:2i]: 00 hold, 01 reset(q->0), 10 set(q->1), 11 toggle.
- gnt  out  NREQ  one-hot, one-cycle grant pulse; cmd of winner captured on same edge.
- j  out  1  to jkf j, registered.
- k  out  1  to jkf k, registered.
- q  in  1  from jkf q.
- rsp_valid  out  1  one-cycle pulse, q result available.
- rsp_id  out  IDW  ID of requester the response belongs to.
- rsp_q  out  1  sampled q after the command took effect.
- busy  out  1  high while state != IDLE.
- err  out  1  sticky mismatch flag: sampled q differs from shadow prediction.

Behaviour:
- Reset (reset=0, async): state=IDLE; gnt=0, j=0, k=0; rsp_valid=0, rsp_id=0, rsp_q=0; busy=0, err=0.
  - Also: rr pointer last=NREQ-1, so requester 0 wins first; shadow_valid=0.
  - Reset asserted mid-operation aborts it; no response is issued.
- FSM: IDLE -> DRIVE -> SAMPLE -> IDLE. One operation per 3 cycles.
- IDLE, at an edge E0 with any req bit set:
  - Winner = first set bit searching from last+1 upward, wrapping modulo NREQ.
  - Registered on E0: gnt[winner]=1 for one cycle; {j,k}=cmd[winner] (hold->00, reset->01, set->10, toggle->11); win_id=winner; last=winner.
  - State -> DRIVE.
  - No req at E0: stay IDLE, all pulses 0.
- DRIVE: j/k stable for the whole cycle; jkf updates on edge E1. On E1: j=k=0, gnt=0, state -> SAMPLE.
- SAMPLE: on E2, register rsp_q=q, rsp_id=win_id, rsp_valid=1 (one cycle); state -> IDLE.
  - Response is visible in the cycle after E2; E3 may grant the next requester in that same cycle.
- req bits are ignored outside IDLE. A requester must drop req or change cmd only after seeing its gnt. A req still high after gnt is treated as a new request.
- Shadow model, updated on E2:
  - reset: pred=0, shadow_valid=1.
  - set: pred=1, shadow_valid=1.
  - toggle: pred=~shadow; shadow_valid unchanged.
  - hold: pred=shadow; shadow_valid unchanged.
  - If shadow_valid was already 1 (or the op is set/reset) and q != pred: err<=1 (stays set until reset).
  - After the check, shadow=q.
- Single requester with req held: granted every 3 cycles. All requesters active: each granted once per 3*NREQ cycles.
- gnt is always one-hot or zero; rsp_valid never overlaps gnt of the same operation.

Test Plan:
- Reset release, req=0001, cmd0=10 (set) -> gnt=0001 on E0; j=1, k=0 during DRIVE; rsp_valid 2 cycles after gnt with rsp_id=0, rsp_q=1, err=0.
- req=1111 held, cmds all 11 (toggle) after an initial reset op -> grants 0001, 0010, 0100, 1000, 0001 spaced 3 cycles apart; rsp_q alternates 1, 0, 1, 0; err stays 0.
- req=0101 at the same edge after last=0 -> requester 2 granted first, then requester 0; rsp_id 2 then 0.
- Force jkf q stuck at 0, then issue set (cmd 10) -> rsp_q=0, err=1 and err stays 1 through subsequent correct ops until reset.
- Assert reset during DRIVE (j=1 high) -> j, k, gnt, busy go 0 immediately with no rsp_valid; after release requester 0 has priority again and shadow_valid=0 (a hold op does not set err).
- Hold cmd (00) before any set/reset with q=1 -> rsp_q=1, err=0.
